load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/risc16_pkg.sv | 26 ++
 rtl/lsu_addr_check.sv | 27 ++
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// ---------------------------------------------------------------------------
// risc16_pkg
// Shared definitions for the RISC16 load/store path: datapath and register
// index width defaults, the LSU FSM state encoding, and a small helper.
// ---------------------------------------------------------------------------
package risc16_pkg;

  // Default datapath/address width and register-index width (8 GPRs).
  localparam int unsigned LSU_DATA_W = 16;
  localparam int unsigned LSU_REG_AW = 3;

  // Load/store unit FSM states.
  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_LD_WAIT = 2'd1,
    LSU_WB_HOLD = 2'd2
  } lsu_state_e;

  // A load is accepted when the handshake completes with the store flag low.
  function automatic logic lsu_is_load_accept(input logic valid,
                                              input logic ready,
                                              input logic we);
    return valid & ready & ~we;
  endfunction

endpackage : risc16_pkg

// File: rtl/lsu_addr_check.sv
// ---------------------------------------------------------------------------
// lsu_addr_check
// Combinational range compare: flags an address that lies outside the
// data memory (addr >= DMEM_DEPTH). Only instantiated when the optional
// address check (macro LSU_ADDR_CHECK_EN) is enabled.
//
// Ports:
//   addr     (in,  DATA_W) address to check
//   addr_oob (out, 1)      1 when addr is beyond the last memory word
// ---------------------------------------------------------------------------
module lsu_addr_check #(
  parameter int DATA_W     = 16,
  parameter int DMEM_DEPTH = 256
) (
  input  logic [DATA_W-1:0] addr,
  output logic              addr_oob
);

  // One extra bit so a depth equal to 2**DATA_W still compares correctly.
  localparam logic [DATA_W:0] DEPTH_LIMIT = (DATA_W+1)'(DMEM_DEPTH);

  // Out-of-range compare.
  always_comb begin
    addr_oob = ({1'b0, addr} >= DEPTH_LIMIT);
  end

endmodule : lsu_addr_check

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Bridges the execute stage to a 1-cycle-latency data memory and returns
// load results to writeback through a valid/ready handshake.
//
// Stores write the memory on their accept edge and produce no response.
// Loads go IDLE -> LD_WAIT (memory read in flight) -> WB_HOLD (result held
// until wb_ready). A new request may be accepted in the WB_HOLD handshake
// cycle, giving one load every two cycles when writeback never stalls.
//
// Optional feature (macro LSU_ADDR_CHECK_EN): addresses >= DMEM_DEPTH are
// rejected -- stores are suppressed, loads return 0 with wb_fault=1.
// Without the macro wb_fault is tied low and the memory wraps addresses.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready execute-side handshake
//   req_we              1 = store, 0 = load
//   req_addr, req_wdata address (ALU result) and store data
//   req_rd              load destination register
//   WE_dmem             memory write enable (combinational, accept cycle)
//   dmem_addr/dmem_wdata memory address/data (pass-through on accept, else held)
//   mem_out             memory read data (valid one cycle after accept)
//   wb_valid/wb_ready   writeback handshake
//   wb_rd, wb_data      destination register and loaded value
//   wb_fault            out-of-range load indication
// ---------------------------------------------------------------------------
module load_store_unit
  import risc16_pkg::*;
#(
  parameter int DATA_W     = LSU_DATA_W,
  parameter int REG_AW     = LSU_REG_AW,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [REG_AW-1:0] req_rd,
  output logic              WE_dmem,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] mem_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_fault
);

  lsu_state_e        state_q, state_d;
  logic              accept_s;
  logic              ld_accept_s;
  logic              st_accept_s;
  logic              addr_oob_s;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wb_valid_q, wb_valid_d;

`ifdef LSU_ADDR_CHECK_EN
  logic              oob_q, oob_d;
  logic              wb_fault_q, wb_fault_d;

  lsu_addr_check #(
    .DATA_W     (DATA_W),
    .DMEM_DEPTH (DMEM_DEPTH)
  ) u_addr_check (
    .addr     (req_addr),
    .addr_oob (addr_oob_s)
  );
`else
  assign addr_oob_s = 1'b0;
`endif

  // State and datapath registers; reset discards any load in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LSU_IDLE;
      addr_q     <= {DATA_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      wb_data_q  <= {DATA_W{1'b0}};
      rd_q       <= {REG_AW{1'b0}};
      wb_valid_q <= 1'b0;
`ifdef LSU_ADDR_CHECK_EN
      oob_q      <= 1'b0;
      wb_fault_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_data_q  <= wb_data_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
`ifdef LSU_ADDR_CHECK_EN
      oob_q      <= oob_d;
      wb_fault_q <= wb_fault_d;
`endif
    end
  end

  // Handshake decode and memory-side outputs.
  always_comb begin
    req_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        LSU_IDLE:    req_ready = 1'b1;
        LSU_WB_HOLD: req_ready = wb_ready;
        default:     req_ready = 1'b0;
      endcase
    end else begin
      req_ready = 1'b0;
    end
    accept_s    = req_valid & req_ready;
    ld_accept_s = lsu_is_load_accept(req_valid, req_ready, req_we);
    st_accept_s = accept_s & req_we;
    // Write happens on the accept edge itself; out-of-range stores are dropped.
    WE_dmem     = st_accept_s & ~addr_oob_s;
    if (accept_s) begin
      dmem_addr  = req_addr;
      dmem_wdata = req_wdata;
    end else begin
      dmem_addr  = addr_q;
      dmem_wdata = wdata_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (ld_accept_s) begin
          state_d = LSU_LD_WAIT;
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_LD_WAIT: begin
        state_d = LSU_WB_HOLD;
      end
      LSU_WB_HOLD: begin
        if (wb_ready) begin
          // A load accepted in the handshake cycle goes straight back to waiting.
          if (ld_accept_s) begin
            state_d = LSU_LD_WAIT;
          end else begin
            state_d = LSU_IDLE;
          end
        end else begin
          state_d = LSU_WB_HOLD;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    addr_d     = accept_s ? req_addr  : addr_q;
    wdata_d    = accept_s ? req_wdata : wdata_q;
    rd_d       = ld_accept_s ? req_rd : rd_q;
    wb_valid_d = (state_d == LSU_WB_HOLD);
    wb_data_d  = wb_data_q;
`ifdef LSU_ADDR_CHECK_EN
    oob_d      = ld_accept_s ? addr_oob_s : oob_q;
    wb_fault_d = wb_fault_q;
    if (state_q == LSU_LD_WAIT) begin
      wb_data_d  = oob_q ? {DATA_W{1'b0}} : mem_out;
      wb_fault_d = oob_q;
    end else begin
      wb_data_d  = wb_data_q;
      wb_fault_d = wb_fault_q;
    end
`else
    if (state_q == LSU_LD_WAIT) begin
      wb_data_d = mem_out;
    end else begin
      wb_data_d = wb_data_q;
    end
`endif
  end

  // Writeback outputs come straight from registers.
  always_comb begin
    wb_valid = wb_valid_q;
    wb_rd    = rd_q;
    wb_data  = wb_data_q;
`ifdef LSU_ADDR_CHECK_EN
    wb_fault = wb_fault_q;
`else
    wb_fault = 1'b0;
`endif
  end

endmodule : load_store_unit
